waveform_input: RTL and testbench

- Receive-side counterpart of the DAC output gearbox.
- Captures one 64-bit ADC sample word per adc_clk cycle and aligns the start of capture to ADC_READY & ADC_LMFC.
- Packs three consecutive beats into one 192-bit word, lane 0 = first beat.
- Buffers packed words in a small show-ahead FIFO with a valid/ready interface to the downstream waveform store. Overflow is flagged and counted.

---
 rtl/waveform_input.sv | 164 ++++++++++++++++
 tb/tb_waveform_input.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_input.sv
// waveform_input: receive-side ADC capture gearbox.
// Aligns capture start to ADC_READY & ADC_LMFC, packs three 64-bit beats
// into one 192-bit word (lane 0 = first beat), and buffers packed words in
// a show-ahead FIFO with a valid/ready interface.
//
// State table:
//   state | meaning
//   IDLE  | capture disabled, nothing latched
//   ARM   | capture enabled, waiting for ADC_READY & ADC_LMFC alignment
//   WORK  | capturing beats, pushing a packed word every third cycle
//
// Ports:
//   adc_clk      - sample clock, all logic on rising edge
//   rst          - synchronous active-high reset
//   adc_i_data   - 64-bit ADC sample word, valid every cycle
//   ADC_READY    - converter link up
//   ADC_LMFC     - multiframe alignment pulse
//   capture_en   - level, arms and holds capture
//   adc_o_data   - packed word at FIFO head {beat2, beat1, beat0}
//   adc_o_valid  - FIFO non-empty
//   adc_o_ready  - downstream accepts; pop on valid & ready
//   overflow     - sticky drop flag
//   clr_overflow - clears overflow (a same-cycle drop wins)
//   drop_count   - saturating count of dropped packed words
//   capturing    - high while in WORK
module waveform_input #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic [63:0]      adc_i_data,
    input  logic             ADC_READY,
    input  logic             ADC_LMFC,
    input  logic             capture_en,
    output logic [191:0]     adc_o_data,
    output logic             adc_o_valid,
    input  logic             adc_o_ready,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic             capturing
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] WORK = 2'd2;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [1:0]    state;
    logic [1:0]    beat;
    logic [63:0]   lane0;
    logic [63:0]   lane1;
    logic [191:0]  fifo_q [FIFO_DEPTH];
    logic [AW:0]   fifo_cnt;

    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [AW:0]   wr_pos;
    logic [AW-1:0] wr_idx;

    always_comb begin
        push    = (state == WORK) && capture_en && ADC_READY && (beat == 2'd2);
        pop     = (fifo_cnt != '0) && adc_o_ready;
        full    = (fifo_cnt == FULL_CNT);
        // A pop frees the head slot, so a push at full is still accepted.
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        // Entry 0 is always the head; after a pop the tail moves down by one.
        wr_pos  = pop ? (fifo_cnt - ONE_CNT) : fifo_cnt;
        wr_idx  = wr_pos[AW-1:0];
    end

    assign adc_o_data  = fifo_q[0];
    assign adc_o_valid = (fifo_cnt != '0);
    assign capturing   = (state == WORK);

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
            lane0 <= '0;
            lane1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture_en) state <= ARM;
                end
                ARM: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (ADC_READY && ADC_LMFC) begin
                        // The alignment cycle's data is beat 0.
                        state <= WORK;
                        lane0 <= adc_i_data;
                        beat  <= 2'd1;
                    end
                end
                WORK: begin
                    if (!capture_en) begin
                        state <= IDLE;
                        beat  <= 2'd0;
                    end else if (!ADC_READY) begin
                        state <= ARM;
                        beat  <= 2'd0;
                    end else begin
                        case (beat)
                            2'd0: begin
                                lane0 <= adc_i_data;
                                beat  <= 2'd1;
                            end
                            2'd1: begin
                                lane1 <= adc_i_data;
                                beat  <= 2'd2;
                            end
                            default: beat <= 2'd0;
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            fifo_cnt <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i + 1];
            end
            // Beat 2 goes straight from the input into the FIFO.
            if (push_ok) fifo_q[wr_idx] <= {adc_i_data, lane1, lane0};
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + ONE_CNT;
                2'b01:   fifo_cnt <= fifo_cnt - ONE_CNT;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_waveform_input.sv
// Testbench for waveform_input: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based reference model.
module tb_waveform_input;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_WORK = 2;

    logic           adc_clk = 1'b0;
    logic           rst;
    logic [63:0]    adc_i_data;
    logic           ADC_READY;
    logic           ADC_LMFC;
    logic           capture_en;
    logic [191:0]   adc_o_data;
    logic           adc_o_valid;
    logic           adc_o_ready;
    logic           overflow;
    logic           clr_overflow;
    logic [CW-1:0]  drop_count;
    logic           capturing;

    int checks   = 0;
    int failures = 0;

    logic [191:0] exp_q [$];
    logic [63:0]  part  [$];
    int           mode;
    logic         m_ovf;
    int           m_drops;

    always #5 adc_clk = ~adc_clk;

    waveform_input #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .adc_i_data   (adc_i_data),
        .ADC_READY    (ADC_READY),
        .ADC_LMFC     (ADC_LMFC),
        .capture_en   (capture_en),
        .adc_o_data   (adc_o_data),
        .adc_o_valid  (adc_o_valid),
        .adc_o_ready  (adc_o_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_count   (drop_count),
        .capturing    (capturing)
    );

    task automatic chkw(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference model: one call per rising edge with the inputs of that edge.
    task automatic model_step();
        logic         do_pop;
        logic         have_word;
        logic         was_full;
        logic         drop;
        logic [191:0] w;
        if (rst) begin
            exp_q.delete();
            part.delete();
            mode    = M_IDLE;
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        do_pop    = (exp_q.size() > 0) && adc_o_ready;
        have_word = 1'b0;
        w         = '0;
        case (mode)
            M_IDLE: if (capture_en) mode = M_ARM;
            M_ARM: begin
                if (!capture_en) mode = M_IDLE;
                else if (ADC_READY && ADC_LMFC) begin
                    mode = M_WORK;
                    part.delete();
                    part.push_back(adc_i_data);
                end
            end
            default: begin
                if (!capture_en) begin
                    mode = M_IDLE;
                    part.delete();
                end else if (!ADC_READY) begin
                    mode = M_ARM;
                    part.delete();
                end else begin
                    part.push_back(adc_i_data);
                    if (part.size() == 3) begin
                        w = {part[2], part[1], part[0]};
                        have_word = 1'b1;
                        part.delete();
                    end
                end
            end
        endcase
        was_full = (exp_q.size() == DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        drop = 1'b0;
        if (have_word) begin
            if (was_full && !do_pop) drop = 1'b1;
            else exp_q.push_back(w);
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        if (drop && (m_drops < (2 ** CW) - 1)) m_drops++;
    endtask

    task automatic check_all();
        chk1("valid", adc_o_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chkw("head_data", adc_o_data, exp_q[0]);
        chk1("overflow", overflow, m_ovf);
        chkw("drop_count", 192'(drop_count), 192'(m_drops));
        chk1("capturing", capturing, mode == M_WORK);
    endtask

    task automatic cyc();
        @(posedge adc_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [63:0] d, input logic l);
        adc_i_data = d;
        ADC_LMFC   = l;
        cyc();
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) drive({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    // Leaves the DUT in WORK with the alignment beat (beat 0) taken.
    task automatic align();
        capture_en = 1'b0;
        drive({$urandom, $urandom}, 1'b0);
        capture_en = 1'b1;
        ADC_READY  = 1'b1;
        drive({$urandom, $urandom}, 1'b0);
        drive({$urandom, $urandom}, 1'b1);
        ADC_LMFC = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        adc_i_data   = '0;
        ADC_READY    = 1'b0;
        ADC_LMFC     = 1'b0;
        capture_en   = 1'b0;
        adc_o_ready  = 1'b0;
        clr_overflow = 1'b0;
        mode         = M_IDLE;
        m_ovf        = 1'b0;
        m_drops      = 0;
        cyc();
        cyc();
        rst = 1'b0;
        chkw("reset_data", adc_o_data, '0);
        chk1("reset_valid", adc_o_valid, 1'b0);

        // Alignment with incrementing data, LMFC at cycle 10.
        capture_en  = 1'b1;
        ADC_READY   = 1'b1;
        adc_o_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            drive(64'(n), n == 10);
            if (n == 9) chk1("no_capture_before_lmfc", capturing, 1'b0);
            if (n == 12) begin
                chk1("first_word_valid", adc_o_valid, 1'b1);
                chkw("first_word", adc_o_data, {64'd12, 64'd11, 64'd10});
            end
            if (n == 15) chkw("second_word", adc_o_data, {64'd15, 64'd14, 64'd13});
        end

        // Backpressure: six words into a four-deep FIFO.
        adc_o_ready = 1'b0;
        align();
        beats(11);
        chk1("full_no_overflow", overflow, 1'b0);
        beats(3);
        chk1("overflow_after_5th", overflow, 1'b1);
        chkw("drops_after_5th", 192'(drop_count), 192'(1));
        beats(3);
        chkw("drops_after_6th", 192'(drop_count), 192'(2));

        // clr_overflow coinciding with a drop, then alone.
        beats(2);
        clr_overflow = 1'b1;
        beats(1);
        clr_overflow = 1'b0;
        chk1("clr_with_drop", overflow, 1'b1);
        chkw("drops_after_7th", 192'(drop_count), 192'(3));
        clr_overflow = 1'b1;
        beats(1);
        clr_overflow = 1'b0;
        chk1("clr_alone", overflow, 1'b0);
        adc_o_ready = 1'b1;
        beats(4);

        // Drain, then push and pop together at full.
        capture_en = 1'b0;
        beats(6);
        chk1("drained", adc_o_valid, 1'b0);
        adc_o_ready = 1'b0;
        align();
        beats(13);
        adc_o_ready = 1'b1;
        beats(1);
        adc_o_ready = 1'b0;
        chk1("full_pushpop_no_ovf", overflow, 1'b0);
        adc_o_ready = 1'b1;
        beats(12);

        // Link drop after beat 1.
        capture_en = 1'b0;
        beats(6);
        align();
        drive({$urandom, $urandom}, 1'b0);
        ADC_READY = 1'b0;
        drive({$urandom, $urandom}, 1'b0);
        chk1("link_drop_to_arm", capturing, 1'b0);
        ADC_READY = 1'b1;
        for (int i = 0; i < 3; i++) drive({$urandom, $urandom}, 1'b0);
        chk1("link_drop_no_partial", adc_o_valid, 1'b0);
        drive(64'hA0, 1'b1);
        drive(64'hB0, 1'b0);
        drive(64'hC0, 1'b0);
        chkw("realigned_word", adc_o_data, {64'hC0, 64'hB0, 64'hA0});

        // capture_en drop mid-word, then re-arm.
        align();
        drive({$urandom, $urandom}, 1'b0);
        capture_en = 1'b0;
        drive({$urandom, $urandom}, 1'b1);
        chk1("en_drop_idle", capturing, 1'b0);
        capture_en = 1'b1;
        for (int i = 0; i < 3; i++) drive({$urandom, $urandom}, 1'b0);
        chk1("en_drop_no_partial", adc_o_valid, 1'b0);
        chk1("en_drop_waits_lmfc", capturing, 1'b0);
        drive(64'h1, 1'b1);
        drive(64'h2, 1'b0);
        drive(64'h3, 1'b0);
        chkw("rearm_word", adc_o_data, {64'h3, 64'h2, 64'h1});

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            capture_en   = ($urandom_range(0, 19) != 0);
            ADC_READY    = ($urandom_range(0, 15) != 0);
            adc_o_ready  = ($urandom_range(0, 2) != 0);
            clr_overflow = ($urandom_range(0, 9) == 0);
            drive({$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end
        clr_overflow = 1'b0;

        // Reset mid-stream.
        ADC_READY   = 1'b1;
        adc_o_ready = 1'b0;
        align();
        beats(5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chkw("midrst_data", adc_o_data, '0);
        chk1("midrst_valid", adc_o_valid, 1'b0);
        chk1("midrst_overflow", overflow, 1'b0);
        chkw("midrst_drops", 192'(drop_count), '0);
        chk1("midrst_capturing", capturing, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
